// File: rtl/path_pkg.sv
// Shared constants and FSM state type for the path capture unit.
package path_pkg;

    localparam int unsigned NODE_W   = 5;
    localparam int unsigned DEPTH    = 16;
    localparam logic [31:0] NODE_ADR = 32'h0200_0008;
    localparam logic [31:0] DONE_ADR = 32'h0200_000C;

    typedef enum logic [1:0] {
        CAPTURE,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/path_capture_unit_if.sv
// CPU store bus plus the node valid/ready stream toward the navigation controller.
interface path_capture_unit_if #(
    parameter int unsigned NODE_W = path_pkg::NODE_W
);
    logic              MemWrite;
    logic [31:0]       DataAdr;
    logic [31:0]       WriteData;
    logic              node_ready;
    logic              node_valid;
    logic [NODE_W-1:0] node_id;

    modport master (
        output MemWrite, DataAdr, WriteData, node_ready,
        input  node_valid, node_id
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, node_ready,
        output node_valid, node_id
    );
endinterface

// File: rtl/path_node_ram.sv
// Node storage: one synchronous write port, one combinational read port, no reset.
module path_node_ram #(
    parameter int unsigned DEPTH  = path_pkg::DEPTH,
    parameter int unsigned NODE_W = path_pkg::NODE_W,
    parameter int unsigned ADR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADR_W-1:0]  wr_addr,
    input  logic [NODE_W-1:0] wr_data,
    input  logic [ADR_W-1:0]  rd_addr,
    output logic [NODE_W-1:0] rd_data
);
    logic [NODE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/path_capture_unit.sv
// Captures path nodes written by the CPU, then streams them out over valid/ready.
module path_capture_unit #(
    parameter logic [31:0] NODE_ADR = path_pkg::NODE_ADR,
    parameter logic [31:0] DONE_ADR = path_pkg::DONE_ADR,
    parameter int unsigned DEPTH    = path_pkg::DEPTH,
    parameter int unsigned NODE_W   = path_pkg::NODE_W
) (
    input  logic                clk,
    input  logic                reset,
    path_capture_unit_if.slave  bus,
    input  logic                clear,
    output logic [4:0]          path_len,
    output logic                path_found,
    output logic                overflow,
    output logic                node_err
);
    import path_pkg::*;

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [NODE_W-1:0] rd_data;
    logic              node_store, done_store, accept, handshake, last_node;

    assign node_store = (state == CAPTURE) && bus.MemWrite && (bus.DataAdr == NODE_ADR);
    assign done_store = (state == CAPTURE) && bus.MemWrite && (bus.DataAdr == DONE_ADR)
                        && (bus.WriteData == 32'd1);
    // clear outranks a same-cycle store, so the RAM write is gated too
    assign accept     = node_store && (path_len < DEPTH_L) && !clear && !reset;
    assign handshake  = bus.node_valid && bus.node_ready;
    assign last_node  = (5'(rd_ptr) == (path_len - 5'd1));

    path_node_ram #(
        .DEPTH  (DEPTH),
        .NODE_W (NODE_W)
    ) u_ram (
        .clk     (clk),
        .we      (accept),
        .wr_addr (wr_ptr),
        .wr_data (bus.WriteData[NODE_W-1:0]),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            CAPTURE: if (done_store) state_nxt = (path_len != '0) ? STREAM : DONE;
            STREAM:  if (handshake && last_node) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            path_len   <= '0;
            path_found <= 1'b0;
            overflow   <= 1'b0;
            node_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                path_len <= path_len + 5'd1;
            end
            if (node_store && !accept) overflow <= 1'b1;
            if (node_store && (|bus.WriteData[31:NODE_W])) node_err <= 1'b1;
            if (done_store) path_found <= 1'b1;
            if (handshake) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.node_valid = (state == STREAM) && !reset;
    assign bus.node_id    = bus.node_valid ? rd_data : '0;
endmodule

// File: doc/path_capture_unit.md
PATH_CAPTURE_UNIT -- requirements
Module: path_capture_unit

Interface
REQ-001 SHALL provide parameter NODE_ADR, default 32'h02000008, the CPU store address carrying one path node.
REQ-002 SHALL provide parameter DONE_ADR, default 32'h0200000C, the CPU store address carrying the path-complete flag.
REQ-003 SHALL provide parameter DEPTH, default 16, the maximum number of stored nodes.
REQ-004 SHALL provide parameter NODE_W, default 5, the node id width.
REQ-005 SHALL provide port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL provide port reset, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL provide port MemWrite, input, 1 bit, the CPU store strobe.
REQ-008 SHALL provide port DataAdr, input, 32 bits, the CPU store address.
REQ-009 SHALL provide port WriteData, input, 32 bits, the CPU store data.
REQ-010 SHALL provide port clear, input, 1 bit, a single-cycle request to restart capture.
REQ-011 SHALL provide port node_ready, input, 1 bit, the downstream navigation controller accepting a node.
REQ-012 SHALL provide port node_valid, output, 1 bit, asserted while node_id holds a valid node.
REQ-013 SHALL provide port node_id, output, NODE_W bits, the current path node.
REQ-014 SHALL provide port path_len, output, 5 bits, the number of nodes stored (0..16).
REQ-015 SHALL provide port path_found, output, 1 bit, set once the path is complete.
REQ-016 SHALL provide port overflow, output, 1 bit, sticky; set when a node is dropped because the buffer is full.
REQ-017 SHALL provide port node_err, output, 1 bit, sticky; set when a node store has WriteData[31:NODE_W] nonzero.

Function
REQ-018 The FSM SHALL have exactly three states: CAPTURE, STREAM and DONE.
REQ-019 In CAPTURE, a cycle with MemWrite=1 and DataAdr==NODE_ADR SHALL store WriteData[NODE_W-1:0] at wr_ptr and increment path_len, both at that clock edge.
REQ-020 A node store SHALL be accepted only if path_len<DEPTH; otherwise it is dropped, path_len holds at 16, and overflow is set.
REQ-021 A node store with upper data bits nonzero SHALL still be stored, truncated to NODE_W bits, and SHALL set node_err.
REQ-022 In CAPTURE, MemWrite=1 with DataAdr==DONE_ADR and WriteData==1 SHALL set path_found at the next edge.
REQ-023 On that DONE_ADR store, the FSM SHALL move to STREAM if path_len>0, or to DONE if path_len==0.
REQ-024 A DONE_ADR store with WriteData!=1 SHALL be ignored.
REQ-025 Stores to any other address SHALL be ignored in every state.
REQ-026 In STREAM, node_valid SHALL be 1 and node_id SHALL equal mem[rd_ptr], rd_ptr starting at 0; the first node_valid appears the cycle after the DONE_ADR store.
REQ-027 In STREAM, a cycle with node_valid&node_ready SHALL increment rd_ptr; when the accepted node is at index path_len-1, the FSM SHALL move to DONE at that edge.
REQ-028 node_id SHALL remain stable while node_valid=1 and node_ready=0.
REQ-029 In STREAM and DONE, node and done stores SHALL be ignored.
REQ-030 In DONE, node_valid SHALL be 0, and path_found and path_len SHALL hold.
REQ-031 In any state, clear=1 SHALL at the next edge return the FSM to CAPTURE and zero wr_ptr, rd_ptr, path_len, path_found, overflow and node_err; clear in STREAM aborts streaming.
REQ-032 A node store in the same cycle as clear SHALL be discarded, because clear has priority.
REQ-033 Pointers SHALL be 4 bits; path_len SHALL be 5 bits; there is no wrap-around because writes saturate at DEPTH.

Reset
REQ-034 reset=1 at a clock edge SHALL force state CAPTURE and zero all pointers and path_len.
REQ-035 Under reset, node_valid, node_id, path_found, overflow and node_err SHALL all be 0; reset overrides clear and any store.
REQ-036 Node storage contents SHALL not need reset; node_id is masked to 0 whenever node_valid=0.

Structure
REQ-037 Shared package path_pkg SHALL hold NODE_W, DEPTH, NODE_ADR, DONE_ADR and the state enum (CAPTURE, STREAM, DONE).
REQ-038 Node storage SHALL be a sub-module path_node_ram: DEPTH x NODE_W, one synchronous write port, one combinational read port.
REQ-039 The FSM, pointers and flags SHALL reside in path_capture_unit.

Verification
REQ-040 Scenario: store nodes 3,7,12,0 to NODE_ADR, then store 1 to DONE_ADR, with node_ready held at 1. Required: path_found=1, path_len=4, node_id sequence 3,7,12,0 on consecutive cycles, then DONE with node_valid=0.
REQ-041 Scenario: 18 node stores with values 0..17, then done. Required: path_len=16, overflow=1, and the streamed nodes are 0..15.
REQ-042 Scenario: store 0x25 to NODE_ADR. Required: stored node=5 and node_err=1.
REQ-043 Scenario: during STREAM, hold node_ready=0 for 3 cycles. Required: node_id holds its value and rd_ptr does not advance.
REQ-044 Scenario: store 2 to DONE_ADR, then store 1 to DONE_ADR with no nodes stored. Required: the first store is ignored; the second gives path_found=1, direct entry to DONE, and node_valid never asserted.
REQ-045 Scenario: assert clear mid-STREAM, then capture a new 2-node path. Required: all flags cleared the next cycle, then the new path streams from index 0.
